// File: rtl/general_fifo_rd_prefetch.sv
// Read-side prefetch: issues RAM-latency FIFO reads ahead of demand and presents a FWFT valid/ready stream.
// Latency: out_valid rises RD_LAT+2 cycles after fifo_rd_empty falls with the buffer empty.
// Backpressure: credit-limited reads (level + in-flight + issue <= BUF_DEPTH); out_ready never reaches the RAM combinationally.
module general_fifo_rd_prefetch #(
    parameter int DAT_WIDTH = 20,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 3,
    parameter int LVL_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 fifo_rd_empty,
    output logic                 fifo_rd_op,
    input  logic [DAT_WIDTH-1:0] fifo_rd_data,
    output logic                 out_valid,
    output logic [DAT_WIDTH-1:0] out_data,
    input  logic                 out_ready,
    output logic [LVL_W-1:0]     buf_level,
    output logic                 ovf_err
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int SUM_W = LVL_W + 2;

    logic [DAT_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic [RD_LAT-1:0]    pipe_q, pipe_nxt;
    logic                 rd_op_q, rd_op_d;
    logic                 ovf_q;

    logic                 ret, push, pop, full, drop;
    logic [SUM_W-1:0]     lvl_nxt, infl_nxt;

    assign ret        = pipe_q[RD_LAT-1];
    assign full       = (level_q == LVL_W'(BUF_DEPTH));
    assign pop        = (level_q != '0) && out_ready;
    assign push       = ret && !flush && !full;
    assign drop       = ret && !flush && full;
    // The registered strobe is re-qualified by the live empty flag so a read
    // decided one cycle early can never underflow the FIFO.
    assign fifo_rd_op = rd_op_q && !fifo_rd_empty && !flush;

    assign out_valid  = (level_q != '0);
    assign out_data   = mem_q[rd_ptr_q];
    assign buf_level  = level_q;
    assign ovf_err    = ovf_q;

    always_comb begin
        pipe_nxt    = '0;
        pipe_nxt[0] = fifo_rd_op;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_nxt[i] = pipe_q[i-1];
        end
        infl_nxt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            infl_nxt = infl_nxt + SUM_W'(pipe_nxt[i]);
        end
        lvl_nxt = SUM_W'(level_q) + SUM_W'(push) - SUM_W'(pop);
        // Credit is judged on next-cycle occupancy; pop only feeds a register here.
        rd_op_d = !fifo_rd_empty && !flush && ((lvl_nxt + infl_nxt) < SUM_W'(BUF_DEPTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_op_q  <= 1'b0;
            pipe_q   <= '0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_op_q <= rd_op_d;
            ovf_q   <= ovf_q | drop;
            if (flush) begin
                pipe_q   <= '0;
                level_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                pipe_q  <= pipe_nxt;
                level_q <= lvl_nxt[LVL_W-1:0];
                if (push) begin
                    mem_q[wr_ptr_q] <= fifo_rd_data;
                    wr_ptr_q <= (wr_ptr_q == PTR_W'(BUF_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= (rd_ptr_q == PTR_W'(BUF_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_general_fifo_rd_prefetch.sv
// Bench for general_fifo_rd_prefetch: behavioural FIFO/RAM model (RD_LAT=1) plus an in-order scoreboard.
module tb_general_fifo_rd_prefetch;

    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_rd_empty = 1'b1;
    logic          fifo_rd_op;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    buf_level;
    logic          ovf_err;

    logic [DW-1:0] fifo_mem [0:127];
    int            wr_cnt = 0;
    int            rd_idx = 0;
    int            uflow = 0;
    logic [DW-1:0] exp_q [$];
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    general_fifo_rd_prefetch #(
        .DAT_WIDTH(DW), .RD_LAT(1), .BUF_DEPTH(3), .LVL_W(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .fifo_rd_empty(fifo_rd_empty), .fifo_rd_op(fifo_rd_op), .fifo_rd_data(fifo_rd_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .buf_level(buf_level), .ovf_err(ovf_err)
    );

    // FIFO model: registered empty, read data one cycle after the strobe
    always @(posedge clk) begin
        if (fifo_rd_op) begin
            if (fifo_rd_empty) uflow <= uflow + 1;
            fifo_rd_data <= fifo_mem[rd_idx];
            rd_idx <= rd_idx + 1;
        end
        fifo_rd_empty <= (wr_cnt == (fifo_rd_op ? rd_idx + 1 : rd_idx));
    end

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_cnt] = base + DW'(i);
            exp_q.push_back(base + DW'(i));
            wr_cnt++;
        end
    endtask

    task automatic test_reset;
        int seen;
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({fifo_rd_op, out_valid, buf_level, ovf_err} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 00000", {fifo_rd_op, out_valid, buf_level, ovf_err});
        end
        tests++;
        if (out_data !== '0) begin
            fails++; $display("FAIL reset_data: got %h want 0", out_data);
        end
        reset_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_rd_op !== 1'b0 || out_valid !== 1'b0 || buf_level !== 2'd0) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++; $display("FAIL empty_idle: %0d active cycles, want 0", seen);
        end
    endtask

    task automatic test_stream;
        int first, last;
        first = -1; last = -1;
        out_ready = 1'b1;
        @(negedge clk);
        load(16, 20'h00001);
        for (int k = 1; k <= 60 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (out_valid) begin
                if (first < 0) first = k;
                last = k;
                tests++;
                if (out_data !== exp_q[0]) begin
                    fails++; $display("FAIL stream_data: got %h want %h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        tests++;
        if (exp_q.size() !== 0) begin
            fails++; $display("FAIL stream_timeout: %0d words left, want 0", exp_q.size());
        end
        tests++;
        if (first !== 4) begin
            fails++; $display("FAIL stream_latency: first valid at edge %0d, want 4", first);
        end
        tests++;
        if (last - first !== 15) begin
            fails++; $display("FAIL stream_span: %0d cycles, want 15", last - first);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure;
        int pulses, gaps;
        pulses = 0; gaps = 0;
        out_ready = 1'b0;
        load(16, 20'h00001);
        repeat (12) begin
            @(negedge clk);
            if (fifo_rd_op) pulses++;
        end
        tests++;
        if (pulses !== 3) begin
            fails++; $display("FAIL bp_pulses: got %0d want 3", pulses);
        end
        tests++;
        if (buf_level !== 2'd3) begin
            fails++; $display("FAIL bp_level: got %0d want 3", buf_level);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
            if (out_valid) begin
                tests++;
                if (out_data !== exp_q[0]) begin
                    fails++; $display("FAIL bp_data: got %h want %h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end else begin
                gaps++;
            end
            @(negedge clk);
        end
        tests++;
        if (exp_q.size() !== 0 || gaps !== 0) begin
            fails++; $display("FAIL bp_drain: left %0d gaps %0d, want 0 0", exp_q.size(), gaps);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_toggle;
        load(32, 20'h00100);
        for (int k = 0; k < 400 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            out_ready = k[0];
            if (out_valid && out_ready) begin
                tests++;
                if (out_data !== exp_q[0]) begin
                    fails++; $display("FAIL toggle_data: got %h want %h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        tests++;
        if (exp_q.size() !== 0) begin
            fails++; $display("FAIL toggle_count: %0d words left, want 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        tests++;
        if (buf_level !== 2'd0 || ovf_err !== 1'b0) begin
            fails++; $display("FAIL toggle_end: level %0d ovf %b, want 0 0", buf_level, ovf_err);
        end
        exp_q.delete();
    endtask

    task automatic test_flush;
        int k;
        out_ready = 1'b0;
        load(8, 20'h00201);
        k = 0;
        @(negedge clk);
        while (buf_level !== 2'd2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (buf_level !== 2'd2) begin
            fails++; $display("FAIL flush_setup: level %0d want 2", buf_level);
        end
        flush = 1'b1;
        #1;
        tests++;
        if (fifo_rd_op !== 1'b0) begin
            fails++; $display("FAIL flush_rdop: got %b want 0", fifo_rd_op);
        end
        @(negedge clk);
        flush = 1'b0;
        tests++;
        if (buf_level !== 2'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_clear: level %0d valid %b, want 0 0", buf_level, out_valid);
        end
        // two buffered words plus the in-flight return are gone
        repeat (3) void'(exp_q.pop_front());
        out_ready = 1'b1;
        for (int j = 0; j < 60 && exp_q.size() > 0; j++) begin
            if (out_valid) begin
                tests++;
                if (out_data !== exp_q[0]) begin
                    fails++; $display("FAIL flush_data: got %h want %h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        tests++;
        if (exp_q.size() !== 0) begin
            fails++; $display("FAIL flush_drain: %0d words left, want 0", exp_q.size());
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_no_underflow;
        tests++;
        if (uflow !== 0) begin
            fails++; $display("FAIL underflow: %0d reads while empty, want 0", uflow);
        end
    endtask

    task automatic test_reset_mid;
        int k;
        out_ready = 1'b1;
        load(16, 20'h00301);
        k = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || fifo_rd_op !== 1'b1) begin
            fails++; $display("FAIL midrst_setup: valid %b rdop %b, want 1 1", out_valid, fifo_rd_op);
        end
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, fifo_rd_op, buf_level} !== 4'b0) begin
            fails++; $display("FAIL midrst_async: got %b want 0000", {out_valid, fifo_rd_op, buf_level});
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_flush();
        test_no_underflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
